fpu_normalize_round: RTL
========================

Name: fpu_normalize_round

Overview:
Result post-processing stage directly downstream of the FPU arithmetic core. It takes an unbiased, unnormalized sign/exponent/significand result with guard bits and normalizes it iteratively, one shift per cycle. It then rounds to nearest-even, re-applies the bias and packs the result into an IEEE-754 word. It also flags overflow, underflow and inexact results and passes pre-formed special values (inf/NaN) through untouched.

Parameters:
- bitness, 32, total width of the IEEE word; EXP_SIZE/MANT_SIZE/BIAS_COEFF are derived via the shared macros (8/23/127 at 32).
- guard_bits, 3, low significand bits below the LSB, ordered guard, round, sticky.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- input_rdy  in  1  upstream holds the in_* fields valid.
- input_ack  out  1  one-cycle pulse when in_* is captured.
- in_sign  in  1  result sign.
- in_exponent  in  EXP_SIZE+2  signed, unbiased exponent.
- in_significand  in  MANT_SIZE+2+guard_bits  [top]=carry, [top-1]=hidden, then mantissa, then G/R/S (28 bits at 32).
- in_bypass  in  1  in_bypass_value is already a final packed result (inf/NaN).
- in_bypass_value  in  bitness  packed special result.
- output_rdy  out  1  result valid, held until acknowledged.
- output_ack  in  1  downstream accepts the result.
- result  out  bitness  packed IEEE word.
- overflow, underflow, inexact  out  1 each  status, valid while output_rdy=1.

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; input_ack, output_rdy, result and all flags are 0. Reset overrides any state, including mid-NORM and HOLD; the in-flight operation is discarded and no ack is issued.
- States: IDLE, NORM, ROUND, PACK, HOLD.
- IDLE: if input_rdy=1, capture in_*, pulse input_ack for exactly one cycle, go to NORM. If in_bypass=1, load result=in_bypass_value, clear all flags, go straight to HOLD.
- NORM, one action per cycle:
  - carry bit set: shift right 1, exponent+1, shifted-out bit ORed into sticky.
  - else, hidden bit clear and significand nonzero: shift left 1, exponent-1.
  - else, significand zero or hidden set: go to ROUND.
  - At most one right shift occurs; left shifts are bounded by the significand width.
- ROUND: round to nearest, ties to even.
  - increment = G & (R | S | LSB).
  - inexact = G | R | S.
  - If the increment carries out of the hidden bit: shift right 1, exponent+1.
- PACK: biased = exponent + BIAS_COEFF, computed at EXP_SIZE+2 signed width.
  - Zero significand: result = {sign, 0...}; flags 0 apart from inexact.
  - biased >= all-ones exponent: result = {sign, all-ones exponent, 0 mantissa}; overflow=1, inexact=1.
  - biased <= 0: flush to signed zero, no subnormals; underflow=1, inexact=1.
  - Else: result = {sign, biased[EXP_SIZE-1:0], mantissa}.
  - Set output_rdy=1 and go to HOLD.
- HOLD: result and flags stay stable. When output_ack=1 and output_rdy=1 at a posedge: output_rdy=0 and go to IDLE. A new capture is possible at the earliest one cycle later; there is no same-cycle pass-through.
- Latency: capture at edge T, output_rdy high after edge T+k+3 (k = shift count). Bypass: output_rdy high after edge T+1.
- input_rdy is ignored outside IDLE. output_ack is ignored outside HOLD.

Decomposition:
- Shared package fpu_pkg holds:
  - state enum Norm_state_t;
  - packed struct Unpacked_t (sign, signed exponent, significand with guard bits);
  - the G/R/S index constants.
- The existing EXP_SIZE/MANT_SIZE/BIAS_COEFF macros are reused unchanged.
- One combinational sub-module, fpu_round_rne: takes the significand and GRS bits, returns the rounded significand, carry-out and inexact. It is instantiated in the ROUND state path.

Test Plan:
- sign=0, exp=0, sig=1<<26, GRS=0 -> result 0x3F800000, k=0, output_rdy after T+3, no flags.
- sign=0, exp=0, sig=1<<27 (carry) -> 0x40000000, k=1.
- exp=0, sig=1<<20 -> six left shifts, 0x3C800000 (2^-6), output_rdy after T+9.
- Rounding, exp=0:
  - mantissa LSB=0, GRS=100 -> 0x3F800000, inexact=1.
  - mantissa=0x000001, GRS=100 -> 0x3F800002.
  - mantissa all ones, GRS=110 -> 0x40000000 (post-round renormalize).
- Range limits:
  - exp=128, sig=1<<26 -> 0x7F800000, overflow=1.
  - exp=-127 -> 0x00000000, underflow=1.
  - sign=1, sig=0 -> 0x80000000.
- Handshake and reset:
  - in_bypass=1, value 0x7FC00000 -> same value, output_rdy after T+1.
  - Hold output_ack=0 for 5 cycles -> result stable.
  - Assert reset (0) mid-NORM -> all outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_pkg                                                         |
// | Brief    : Shared FPU types, field geometry and format macros.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

`ifndef EXP_SIZE
`define EXP_SIZE(b) (((b) == 64) ? 11 : (((b) == 16) ? 5 : 8))
`endif
`ifndef MANT_SIZE
`define MANT_SIZE(b) ((b) - `EXP_SIZE(b) - 1)
`endif
`ifndef BIAS_COEFF
`define BIAS_COEFF(b) ((1 << (`EXP_SIZE(b) - 1)) - 1)
`endif

package fpu_pkg;

  // Default word geometry; the unpacked operand struct is sized from these.
  localparam int FPU_BITNESS    = 32;
  localparam int FPU_GUARD_BITS = 3;
  localparam int EXP_W          = `EXP_SIZE(FPU_BITNESS);
  localparam int MANT_W         = `MANT_SIZE(FPU_BITNESS);
  localparam int EXP_IN_W       = EXP_W + 2;
  localparam int SIG_W          = MANT_W + 2 + FPU_GUARD_BITS;

  // Positions of the guard/round/sticky bits at the bottom of the significand.
  localparam int GUARD_IDX  = 2;
  localparam int ROUND_IDX  = 1;
  localparam int STICKY_IDX = 0;

  // State encodings, kept as plain constants for legacy tooling.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_PACK  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_NORM  = S_NORM,
    ST_ROUND = S_ROUND,
    ST_PACK  = S_PACK,
    ST_HOLD  = S_HOLD
  } Norm_state_t;

  typedef struct packed {
    logic                       sign;
    logic signed [EXP_IN_W-1:0] exponent;
    logic        [SIG_W-1:0]    significand;
  } Unpacked_t;

endpackage

`default_nettype wire

// File: rtl/fpu_normalize_round_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_normalize_round_if                                          |
// | Brief    : Upstream/downstream handshake bundle of the normalize stage.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

interface fpu_normalize_round_if
  import fpu_pkg::*;
#(
  parameter int bitness    = FPU_BITNESS,
  parameter int guard_bits = FPU_GUARD_BITS
);
  localparam int IF_EXP_W = `EXP_SIZE(bitness) + 2;
  localparam int IF_SIG_W = `MANT_SIZE(bitness) + 2 + guard_bits;

  logic                       input_rdy;
  logic                       input_ack;
  logic                       in_sign;
  logic signed [IF_EXP_W-1:0] in_exponent;
  logic        [IF_SIG_W-1:0] in_significand;
  logic                       in_bypass;
  logic        [bitness-1:0]  in_bypass_value;
  logic                       output_rdy;
  logic                       output_ack;
  logic        [bitness-1:0]  result;
  logic                       overflow;
  logic                       underflow;
  logic                       inexact;

  // Producer/consumer side (arithmetic core and result sink).
  modport master (
    output input_rdy, in_sign, in_exponent, in_significand, in_bypass,
           in_bypass_value, output_ack,
    input  input_ack, output_rdy, result, overflow, underflow, inexact
  );

  // Normalize/round stage side.
  modport slave (
    input  input_rdy, in_sign, in_exponent, in_significand, in_bypass,
           in_bypass_value, output_ack,
    output input_ack, output_rdy, result, overflow, underflow, inexact
  );
endinterface

`default_nettype wire

// File: rtl/fpu_normalize_round_round_rne.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_round_rne                                                   |
// | Brief    : Round-to-nearest-even of a normalized significand using G/R/S.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module fpu_round_rne
  import fpu_pkg::*;
#(
  parameter int mant_w = MANT_W
) (
  input  wire logic [mant_w:0] significand,
  input  wire logic [2:0]      grs,
  output logic      [mant_w:0] rounded,
  output logic                 carry,
  output logic                 inexact
);
  logic w_incr;

  // Increment above half an ulp, or at exactly half when the LSB is odd.
  always_comb begin
    w_incr           = grs[GUARD_IDX] & (grs[ROUND_IDX] | grs[STICKY_IDX] | significand[0]);
    {carry, rounded} = {1'b0, significand} + (mant_w + 2)'(w_incr);
    inexact          = |grs;
  end
endmodule

`default_nettype wire

// File: rtl/fpu_normalize_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_normalize_round                                             |
// | Brief    : Iterative normalize, RNE round, bias and pack of FPU results,   |
// |            with overflow/underflow/inexact status and special bypass.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module fpu_normalize_round
  import fpu_pkg::*;
#(
  parameter int bitness    = FPU_BITNESS,
  parameter int guard_bits = FPU_GUARD_BITS
) (
  input wire logic             clock,
  input wire logic             reset,
  fpu_normalize_round_if.slave bus
);
  localparam int E_W = `EXP_SIZE(bitness);
  localparam int M_W = `MANT_SIZE(bitness);
  localparam int B_C = `BIAS_COEFF(bitness);
  localparam int X_W = E_W + 2;
  localparam int S_W = M_W + 2 + guard_bits;
  localparam int HID = S_W - 2;
  localparam int CRY = S_W - 1;
  localparam logic signed [X_W-1:0] EXP_ALL_ONES = X_W'((1 << E_W) - 1);

  Norm_state_t         r_state;
  Unpacked_t           r_op;
  logic                r_input_ack;
  logic                r_output_rdy;
  logic [bitness-1:0]  r_result;
  logic                r_overflow;
  logic                r_underflow;
  logic                r_inexact;
  logic                r_round_inexact;

  logic [M_W:0]        w_rounded;
  logic                w_round_carry;
  logic                w_round_inexact;
  logic [S_W-1:0]      w_shift_right;
  logic signed [X_W-1:0] w_biased;
  logic                w_sig_zero;

  fpu_round_rne #(.mant_w(M_W)) u_round (
    .significand (r_op.significand[HID -: M_W + 1]),
    .grs         (r_op.significand[GUARD_IDX:STICKY_IDX]),
    .rounded     (w_rounded),
    .carry       (w_round_carry),
    .inexact     (w_round_inexact)
  );

  // Right shift keeps the dropped bit alive in sticky; bias is applied at full signed width.
  always_comb begin
    w_shift_right = {1'b0, r_op.significand[CRY:1]} | S_W'(r_op.significand[STICKY_IDX]);
    w_biased      = $signed(r_op.exponent) + $signed(X_W'(B_C));
    w_sig_zero    = (r_op.significand == '0);
  end

  // Control FSM plus the working operand, result and status registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_op            <= '0;
      r_input_ack     <= 1'b0;
      r_output_rdy    <= 1'b0;
      r_result        <= '0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_inexact       <= 1'b0;
      r_round_inexact <= 1'b0;
    end else begin
      r_input_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.input_rdy) begin
            r_input_ack          <= 1'b1;
            r_op.sign            <= bus.in_sign;
            r_op.exponent        <= bus.in_exponent;
            r_op.significand     <= bus.in_significand;
            r_round_inexact      <= 1'b0;
            if (bus.in_bypass) begin
              // Specials are already packed; output_rdy rises on the next edge in HOLD.
              r_result    <= bus.in_bypass_value;
              r_overflow  <= 1'b0;
              r_underflow <= 1'b0;
              r_inexact   <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_state <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (r_op.significand[CRY]) begin
            r_op.significand <= w_shift_right;
            r_op.exponent    <= r_op.exponent + X_W'(1);
          end else if (!r_op.significand[HID] && !w_sig_zero) begin
            r_op.significand <= {r_op.significand[CRY-1:0], 1'b0};
            r_op.exponent    <= r_op.exponent - X_W'(1);
          end else begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          // A carry out of the hidden bit leaves 10.00..0, renormalized by one right shift.
          r_op.significand <= {1'b0,
                               w_round_carry ? {1'b1, w_rounded[M_W:1]} : w_rounded,
                               {guard_bits{1'b0}}};
          if (w_round_carry) begin
            r_op.exponent <= r_op.exponent + X_W'(1);
          end
          r_round_inexact <= w_round_inexact;
          r_state         <= ST_PACK;
        end
        ST_PACK: begin
          if (w_sig_zero) begin
            r_result    <= {r_op.sign, {(bitness-1){1'b0}}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= r_round_inexact;
          end else if (w_biased >= EXP_ALL_ONES) begin
            r_result    <= {r_op.sign, {E_W{1'b1}}, {M_W{1'b0}}};
            r_overflow  <= 1'b1;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b1;
          end else if (w_biased[X_W-1] || (w_biased == '0)) begin
            // No subnormal support: anything at or below the minimum exponent flushes to zero.
            r_result    <= {r_op.sign, {(bitness-1){1'b0}}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b1;
            r_inexact   <= 1'b1;
          end else begin
            r_result    <= {r_op.sign, w_biased[E_W-1:0], r_op.significand[HID-1 -: M_W]};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= r_round_inexact;
          end
          r_output_rdy <= 1'b1;
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!r_output_rdy) begin
            r_output_rdy <= 1'b1;
          end else if (bus.output_ack) begin
            r_output_rdy <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.input_ack  = r_input_ack;
  assign bus.output_rdy = r_output_rdy;
  assign bus.result     = r_result;
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;
  assign bus.inexact    = r_inexact;
endmodule

`default_nettype wire
